// File: rtl/instruction_register_pkg.sv
// Shared constants for the instruction register and the decode/control logic
// that consumes it.
//   IR_WIDTH   : width of the full instruction word
//   BYTE_WIDTH : width of one loadable half
//   LH_LOW     : LH encoding that selects IROut[7:0]
//   LH_HIGH    : LH encoding that selects IROut[15:8]
package instruction_register_pkg;
  localparam int IR_WIDTH   = 16;
  localparam int BYTE_WIDTH = 8;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  typedef logic [IR_WIDTH-1:0]   ir_word_t;
  typedef logic [BYTE_WIDTH-1:0] ir_byte_t;
endpackage

// File: rtl/instruction_register_if.sv
// Bundle of the byte-load bus and the register readback.
//   I     : byte to load
//   Write : load enable
//   LH    : half select (LH_LOW / LH_HIGH)
//   IROut : full register contents
// master : the side that drives loads (control / bench)
// slave  : the register side
interface instruction_register_if;
  import instruction_register_pkg::*;

  ir_byte_t I;
  logic     Write;
  logic     LH;
  ir_word_t IROut;

  modport master (output I, output Write, output LH, input IROut);
  modport slave  (input I, input Write, input LH, output IROut);
endinterface

// File: rtl/instruction_register.sv
// 16-bit instruction register assembled one byte per clock.
//   Clock : single clock, all updates on the rising edge
//   Reset : synchronous active-high, loads RESET_VALUE, wins over Write
//   I     : byte to load
//   Write : 1 = load the half selected by LH, 0 = hold
//   LH    : 0 = low byte [7:0], 1 = high byte [15:8]
//   IROut : register contents; IROut is the storage itself (no output stage)
module instruction_register
  import instruction_register_pkg::*;
#(
  parameter logic [IR_WIDTH-1:0] RESET_VALUE = 16'h0000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [BYTE_WIDTH-1:0] I,
  input  logic                  Write,
  input  logic                  LH,
  output logic [IR_WIDTH-1:0]   IROut
);

  // LH is deliberately not X-guarded: anything other than LH_HIGH loads the
  // low half, which keeps the decode to a single mux select.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      IROut <= RESET_VALUE;
    end else if (Write) begin
      if (LH == LH_HIGH) IROut[IR_WIDTH-1 -: BYTE_WIDTH] <= I;
      else               IROut[BYTE_WIDTH-1:0]           <= I;
    end
  end

endmodule

// File: tb/tb_instruction_register.sv
module tb_instruction_register;
  import instruction_register_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  instruction_register_if irb ();

  instruction_register dut (
    .Clock (Clock),
    .Reset (Reset),
    .I     (irb.I),
    .Write (irb.Write),
    .LH    (irb.LH),
    .IROut (irb.IROut)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int model = 0;     // reference register value as a plain integer
  int exp_q[$];      // expected IROut after each driven edge

  // Reference: reset clears, otherwise a write replaces one byte by arithmetic.
  function automatic int next_val(int cur, bit rst, bit wr, bit lh, int b);
    if (rst) return 0;
    if (!wr) return cur;
    if (lh)  return (b * 256) + (cur % 256);
    return (cur - (cur % 256)) + b;
  endfunction

  // Inputs change on the falling edge; the result is due after the next rise.
  task automatic step(input bit rst, input bit wr, input bit lh, input int b);
    @(negedge Clock);
    Reset     = rst;
    irb.Write = wr;
    irb.LH    = lh;
    irb.I     = b[7:0];
    model     = next_val(model, rst, wr, lh, b & 255);
    exp_q.push_back(model);
  endtask

  // Bring the register to a known word with a reset and two byte writes.
  task automatic preload(input int w);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, (w / 256) & 255);
    step(1'b0, 1'b1, 1'b0, w & 255);
  endtask

  // Monitor: one pending expectation per rising edge.
  always begin
    int e;
    @(posedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (irb.IROut !== e[15:0]) begin
        bad++;
        $display("FAIL iro_out t=%0t got=%h exp=%h", $time, irb.IROut, e[15:0]);
      end
    end
  end

  initial begin
    irb.Write = 1'b0;
    irb.LH    = 1'b0;
    irb.I     = 8'h00;

    // reset state
    step(1'b1, 1'b0, 1'b0, 0);

    // low-byte write
    preload(16'h2367);
    step(1'b0, 1'b1, 1'b0, 8'h15);
    // high-byte write
    preload(16'h2367);
    step(1'b0, 1'b1, 1'b1, 8'h15);
    // hold with LH/I toggling
    preload(16'h2367);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    // assembly from reset, high then low
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 8'hAB);
    step(1'b0, 1'b1, 1'b0, 8'hCD);
    // reset beats a simultaneous write
    preload(16'hBEEF);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    // reset mid-assembly discards the partial word
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 8'h99);

    // reset pulse between edges has no effect
    preload(16'h1234);
    @(negedge Clock);
    Reset     = 1'b1;
    irb.Write = 1'b0;
    #1;
    total++;
    if (irb.IROut !== model[15:0]) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", irb.IROut, model[15:0]);
    end
    #1;
    Reset = 1'b0;
    exp_q.push_back(model);

    // random traffic, reset kept rare so words get assembled
    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));

    // drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge Clock);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
